// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq_pkg
// Description : Shared ALU select codes, flag indices and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_muldiv_seq_pkg;

    localparam int C_WIDTH = 16;
    localparam int C_CNT_W = 5;

    localparam logic [3:0] IADD = 4'b0000;
    localparam logic [3:0] ISUB = 4'b0001;
    localparam logic [3:0] ISLL = 4'b1000;
    localparam logic [3:0] ISRL = 4'b1010;
    localparam logic [3:0] IIDT = 4'b1100;
    localparam logic [3:0] INON = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq_if
// Description : Start/result handshake between control unit and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_zero;

    modport master (
        output start, op, opa, opb,
        input  busy, done, result_hi, result_lo, div_zero
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, result_hi, result_lo, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Shared 16-bit combinational ALU; flags packed {S, Z, C, V}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_muldiv_seq_pkg::*;
(
    input  wire logic [15:0] data_a_i,
    input  wire logic [15:0] data_b_i,
    input  wire logic [3:0]  s_alu_i,
    output logic      [15:0] alu_out_o,
    output logic      [3:0]  flag_out_o
);
    logic [16:0] w_wide;
    logic        w_v;

    // For ISUB the carry bit is the borrow (set when A < B).
    always_comb begin
        w_wide = 17'd0;
        w_v    = 1'b0;
        case (s_alu_i)
            IADD: begin
                w_wide = {1'b0, data_a_i} + {1'b0, data_b_i};
                w_v    = (data_a_i[15] == data_b_i[15]) && (w_wide[15] != data_a_i[15]);
            end
            ISUB: begin
                w_wide = {1'b0, data_a_i} - {1'b0, data_b_i};
                w_v    = (data_a_i[15] != data_b_i[15]) && (w_wide[15] != data_a_i[15]);
            end
            ISLL:    w_wide = {1'b0, data_a_i << data_b_i[3:0]};
            ISRL:    w_wide = {1'b0, data_a_i >> data_b_i[3:0]};
            IIDT:    w_wide = {1'b0, data_a_i};
            default: w_wide = 17'd0;
        endcase
    end

    assign alu_out_o             = w_wide[15:0];
    assign flag_out_o[FLAG_S]    = w_wide[15];
    assign flag_out_o[FLAG_Z]    = (w_wide[15:0] == 16'd0);
    assign flag_out_o[FLAG_C]    = w_wide[16];
    assign flag_out_o[FLAG_V]    = w_v;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative 16-bit unsigned multiply/divide driving the shared ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_muldiv_seq_if.slave       bus,
    output logic      [WIDTH-1:0] alu_a_o,
    output logic      [WIDTH-1:0] alu_b_o,
    output logic      [3:0]       alu_sel_o,
    input  wire logic [WIDTH-1:0] alu_result_i,
    input  wire logic [3:0]       alu_flag_i
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               dz_q, dz_d;
    logic [WIDTH:0]     w_rs;
    logic               w_carry;
    logic               w_flag_unused;

    assign w_rs          = {hi_q, lo_q[WIDTH-1]};
    assign w_carry       = alu_flag_i[FLAG_C];
    assign w_flag_unused = &{1'b0, alu_flag_i[FLAG_S], alu_flag_i[FLAG_Z], alu_flag_i[FLAG_V]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        dz_d      = dz_q;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sel_o = INON;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    dz_d  = 1'b0;
                    cnt_d = '0;
                    hi_d  = '0;
                    if (bus.op) begin
                        lo_d = bus.opa;
                        b_d  = bus.opb;
                        if (bus.opb == '0) begin
                            state_d  = ST_FIN;
                            res_lo_d = '1;
                            res_hi_d = bus.opa;
                            dz_d     = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        lo_d    = bus.opb;
                        b_d     = bus.opa;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                alu_b_o  = b_q;
                if (!op_q) begin
                    alu_sel_o = IADD;
                    alu_a_o   = hi_q;
                    if (lo_q[0]) {hi_d, lo_d} = {w_carry, alu_result_i, lo_q[WIDTH-1:1]};
                    else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end else begin
                    // A set shifted-out MSB means Rs >= 2^16 > divisor: subtract unconditionally.
                    alu_sel_o = ISUB;
                    alu_a_o   = w_rs[WIDTH-1:0];
                    if (w_rs[WIDTH] || !w_carry) begin
                        hi_d = alu_result_i;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = w_rs[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = ST_FIN;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end
            end
            ST_FIN: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.result_hi = res_hi_q;
    assign bus.result_lo = res_lo_q;
    assign bus.div_zero  = dz_q;

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Iterative 16-bit unsigned multiply/divide sequencer that acts as the initiator for the shared combinational ALU. It drives the ALU operand and select inputs and consumes the ALU result and flag outputs, one iteration per clock. It accepts a start request from the control unit and returns a 32-bit product, or a quotient/remainder pair, with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand width; fixed at 16 to match the ALU datapath.
CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  request; sampled only while in IDLE.
OP  input  1  0 = multiply, 1 = divide.
OPA  input  16  multiplicand or dividend.
OPB  input  16  multiplier or divisor.
BUSY  output  1  high in RUN and FIN states.
DONE  output  1  one-cycle pulse; results are valid from this cycle onward.
RESULT_HI  output  16  product[31:16], or remainder.
RESULT_LO  output  16  product[15:0], or quotient.
DIV_ZERO  output  1  set with DONE when a divide had OPB == 0; cleared on the next accepted START.
ALU_A  output  16  to ALU DATA_A.
ALU_B  output  16  to ALU DATA_B.
ALU_SEL  output  4  to ALU S_ALU.
ALU_RESULT  input  16  from ALU ALU_OUT.
ALU_FLAG  input  4  from ALU FLAG_OUT, packed as {S, Z, C, V}; only C (bit 1) is used.

Behaviour:
- Reset (asynchronous, RST_N low):
  - State goes to IDLE; counter, accumulator, operand registers, RESULT_HI, RESULT_LO and DIV_ZERO clear to 0.
  - BUSY = 0, DONE = 0.
  - Reset during RUN aborts the operation with no DONE pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - ALU_SEL = 4'b1111 (INON), ALU_A = ALU_B = 0.
  - START = 1 at a clock edge latches OP, OPA and OPB, clears DIV_ZERO and the counter, and loads the working registers.
  - The next state is RUN, except for a divide with OPB == 0: next state is FIN, with RESULT_LO = 16'hFFFF, RESULT_HI = OPA and DIV_ZERO = 1.
- Multiply (shift-add), one iteration per RUN cycle:
  - Registers: HI accumulator (16 bits), LO = multiplier.
  - ALU_SEL = IADD (0000), ALU_A = HI, ALU_B = multiplicand.
  - If LO[0] = 1: {C, HI, LO} <= {ALU_FLAG[1], ALU_RESULT, LO} >> 1.
  - Otherwise: {HI, LO} <= {1'b0, HI, LO} >> 1.
- Divide (restoring), one iteration per RUN cycle:
  - Form the shifted value {MSB, Rs} = {R, Q[15]}, where MSB = R[15]; this is combinational from the registers.
  - ALU_SEL = ISUB (0001), ALU_A = Rs, ALU_B = divisor.
  - If MSB = 1 or ALU_FLAG[1] = 0 (no borrow): R <= ALU_RESULT, Q <= {Q[14:0], 1}.
  - Otherwise: R <= Rs, Q <= {Q[14:0], 0}.
- RUN lasts exactly 16 cycles (counter 0..15). The edge at count 15 moves to FIN and loads RESULT_HI/RESULT_LO from HI/LO (multiply) or R/Q (divide).
- FIN: DONE = 1 for exactly one cycle, BUSY = 1, ALU_SEL = INON. The next state is IDLE unconditionally.
- Latency:
  - START edge to DONE high: 17 cycles, or 1 cycle for divide-by-zero.
  - Back-to-back operation: START may be asserted during the FIN cycle; it is sampled at the first IDLE edge, so the minimum issue interval is 18 cycles.
- START while BUSY is ignored, not queued.
- RESULT_HI, RESULT_LO and DIV_ZERO hold their values until the next accepted START.
- All arithmetic is modulo 2^16 through the ALU; no internal adder/subtractor is permitted, and shifts are internal wiring.

Decomposition:
- Shared package: ALU select constants (IADD = 0000, ISUB = 0001, ISLL = 1000, ISRL = 1010, IIDT = 1100, INON = 1111), FLAG bit indices (FLAG_S = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0) and the state enum. The ALU uses the same constants.
- No sub-module: the ALU is instantiated beside this block at the top level. The bench instantiates the real ALU.

Test Plan:
- Multiply 16'h1234 × 16'h5678 -> DONE 17 cycles after START; {RESULT_HI, RESULT_LO} = 32'h0626_0060; DIV_ZERO = 0.
- Multiply 16'hFFFF × 16'hFFFF -> result 32'hFFFE_0001; this exercises the carry path through ALU_FLAG[1] on every iteration.
- Divide 1000 / 7 -> RESULT_LO = 16'h008E, RESULT_HI = 16'h0006. Divide 16'hFFFF / 16'h8001 -> Q = 1, R = 16'h7FFE, which exercises the MSB = 1 path.
- Divide 16'h1234 / 0 -> DONE 1 cycle after START; RESULT_LO = 16'hFFFF, RESULT_HI = 16'h1234, DIV_ZERO = 1. A following multiply 3 × 5 clears DIV_ZERO and gives 32'h0000_000F.
- START pulses at RUN cycles 3 and 10 are ignored; the result matches a single operation. START held during FIN starts the next operation with DONE 18 cycles after the first DONE.
- Pull RST_N low at RUN cycle 8 -> outputs go to 0 immediately with no DONE. After release, a new divide 100 / 10 returns Q = 10, R = 0.
